// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
//
// Program-counter unit for the single-cycle MIPS core. It holds the PC in a
// register and drives instruction memory directly. The next PC is chosen from
// these sources, highest priority first:
//   exception redirect > HALT hold > stall hold > jr > jump > branch > seq
// A two-state RUN/HALT FSM freezes fetch until resume or an exception.
//
// Optional feature (compile-time macro PC_ALIGN_CHECK_EN):
//   defined   : a jr to a target that is not word-aligned is trapped to
//               EXC_VEC. epc captures the PC and misalign pulses for one cycle.
//   undefined : the jr target is forced to word alignment, and misalign is 0.
//
// Parameters
//   WIDTH     PC width in bits (32..64)
//   RESET_VEC PC value loaded on reset
//   EXC_VEC   exception/trap target, zero-extended to WIDTH
//   INC       sequential increment in bytes
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   stall         in   hold PC this cycle
//   branch_taken  in   conditional branch resolved taken
//   branch_offset in   sign-extended word offset (WIDTH)
//   jump          in   J/JAL
//   jump_index    in   26-bit instruction index field
//   jr            in   JR/JALR
//   jr_target     in   register-file value for jr (WIDTH)
//   exc           in   exception request
//   halt          in   enter HALT
//   resume        in   leave HALT
//   pc            out  current PC (registered)
//   pc_plus_inc   out  pc + INC (combinational link value)
//   epc           out  PC of the faulting instruction (registered)
//   halted        out  FSM is in HALT (registered)
//   misalign      out  one-cycle pulse on a trapped misaligned jr
// -----------------------------------------------------------------------------
module pc_unit #(
   parameter int                WIDTH     = 32,
   parameter logic [WIDTH-1:0]  RESET_VEC = '0,
   parameter logic [31:0]       EXC_VEC   = 32'h0000_0080,
   parameter int                INC       = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_offset,
   input  logic             jump,
   input  logic [25:0]      jump_index,
   input  logic             jr,
   input  logic [WIDTH-1:0] jr_target,
   input  logic             exc,
   input  logic             halt,
   input  logic             resume,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus_inc,
   output logic [WIDTH-1:0] epc,
   output logic             halted,
   output logic             misalign
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_epc;
   logic [WIDTH-1:0] w_pc_nxt;
   logic [WIDTH-1:0] w_epc_nxt;
   logic [WIDTH-1:0] w_exc_vec;
   logic [WIDTH-1:0] w_seq;
   logic [WIDTH-1:0] w_br;
   logic [WIDTH-1:0] w_jmp;

`ifdef PC_ALIGN_CHECK_EN
   logic r_misalign;
   logic w_mis_nxt;
`else
   logic [1:0] w_unused_jr_lsb;
   assign w_unused_jr_lsb = jr_target[1:0];
`endif

   // Targets; all sums wrap modulo 2^WIDTH.
   assign w_exc_vec = WIDTH'(EXC_VEC);
   assign w_seq     = r_pc + WIDTH'(INC);
   assign w_br      = w_seq + (branch_offset << 2);
   // Pseudo-direct jump keeps the region bits of the delay-slot address.
   assign w_jmp     = {w_seq[WIDTH-1:28], jump_index, 2'b00};

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_epc_nxt   = r_epc;
`ifdef PC_ALIGN_CHECK_EN
      w_mis_nxt   = 1'b0;
`endif
      if (exc) begin
         // Exception overrides HALT and stall alike.
         w_pc_nxt    = w_exc_vec;
         w_epc_nxt   = r_pc;
         w_state_nxt = ST_RUN;
      end else if (r_state == ST_HALT) begin
         // PC holds on the leaving edge as well; fetch restarts one edge later.
         if (resume) begin
            w_state_nxt = ST_RUN;
         end
      end else if (halt) begin
         w_state_nxt = ST_HALT;
      end else if (stall) begin
         w_pc_nxt = r_pc;
      end else if (jr) begin
`ifdef PC_ALIGN_CHECK_EN
         if (jr_target[1:0] != 2'b00) begin
            w_pc_nxt  = w_exc_vec;
            w_epc_nxt = r_pc;
            w_mis_nxt = 1'b1;
         end else begin
            w_pc_nxt = jr_target;
         end
`else
         w_pc_nxt = {jr_target[WIDTH-1:2], 2'b00};
`endif
      end else if (jump) begin
         w_pc_nxt = w_jmp;
      end else if (branch_taken) begin
         w_pc_nxt = w_br;
      end else begin
         w_pc_nxt = w_seq;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_RUN;
         r_pc    <= RESET_VEC;
         r_epc   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_epc   <= w_epc_nxt;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_mis_nxt;
      end
   end
   assign misalign = r_misalign;
`else
   assign misalign = 1'b0;
`endif

   assign pc          = r_pc;
   assign pc_plus_inc = w_seq;
   assign epc         = r_epc;
   assign halted      = (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall, branch_taken, jump, jr, exc, halt, resume;
   logic [31:0] branch_offset, jr_target;
   logic [25:0] jump_index;
   logic [31:0] pc, pc_plus_inc, epc;
   logic        halted, misalign;

   int total = 0;
   int bad   = 0;

   // Reference state, updated from the spec's rules.
   bit [31:0] m_pc, m_epc;
   bit        m_halted, m_mis;

`ifdef PC_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   pc_unit dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
      .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
      .jr(jr), .jr_target(jr_target), .exc(exc), .halt(halt), .resume(resume),
      .pc(pc), .pc_plus_inc(pc_plus_inc), .epc(epc), .halted(halted),
      .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".pc"},       {32'd0, pc},          {32'd0, m_pc});
      chk({tag, ".epc"},      {32'd0, epc},         {32'd0, m_epc});
      chk({tag, ".halted"},   {63'd0, halted},      {63'd0, m_halted});
      chk({tag, ".misalign"}, {63'd0, misalign},    {63'd0, m_mis});
      chk({tag, ".link"},     {32'd0, pc_plus_inc}, {32'd0, m_pc + 32'd4});
   endtask

   task automatic model_reset();
      m_pc = 32'd0; m_epc = 32'd0; m_halted = 1'b0; m_mis = 1'b0;
   endtask

   // One clock edge of the reference: priority list applied to plain numbers.
   task automatic model_edge();
      bit [31:0] seq;
      seq   = m_pc + 32'd4;
      m_mis = 1'b0;
      if (exc) begin
         m_epc = m_pc; m_pc = 32'h80; m_halted = 1'b0;
      end else if (m_halted) begin
         if (resume) m_halted = 1'b0;
      end else if (halt) begin
         m_halted = 1'b1;
      end else if (stall) begin
         // hold
      end else if (jr) begin
         if (ALIGN_CHK && (jr_target % 4 != 0)) begin
            m_epc = m_pc; m_pc = 32'h80; m_mis = 1'b1;
         end else begin
            m_pc = jr_target - (jr_target % 4);
         end
      end else if (jump) begin
         m_pc = (seq & 32'hF000_0000) + 32'(jump_index) * 4;
      end else if (branch_taken) begin
         m_pc = seq + branch_offset * 4;
      end else begin
         m_pc = seq;
      end
   endtask

   task automatic idle();
      stall = 0; branch_taken = 0; jump = 0; jr = 0; exc = 0; halt = 0; resume = 0;
      branch_offset = '0; jr_target = '0; jump_index = '0;
   endtask

   // Advance one edge, update the model from the inputs seen at that edge,
   // then compare just after the edge.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      chk_all(tag);
   endtask

   task automatic goto_pc(input logic [31:0] a);
      idle(); jr = 1; jr_target = a;
      step("goto");
      idle();
   endtask

   initial begin
      idle();
      reset_n = 1'b0;
      model_reset();
      #1;
      chk_all("reset_async");
      @(posedge clk); @(posedge clk); #1;
      chk_all("reset_held");
      reset_n = 1'b1;

      // Free-running sequence 0,4,8,12
      step("seq1"); step("seq2"); step("seq3");

      // Branch back, then jump forward
      goto_pc(32'h100);
      branch_taken = 1; branch_offset = -32'sd2;
      step("branch_neg");
      idle(); jump = 1; jump_index = 26'h40;
      step("jump");
      chk("jump_pc", {32'd0, pc}, 64'h100);

      // Simultaneous jr/jump/branch: jr wins, then stall
      goto_pc(32'h200);
      jr = 1; jump = 1; branch_taken = 1; jr_target = 32'h400;
      jump_index = 26'h3; branch_offset = 32'd5;
      step("jr_prio");
      chk("jr_prio_pc", {32'd0, pc}, 64'h400);
      idle(); stall = 1;
      step("stall");

      // Halt for 5 cycles despite jump, then resume
      goto_pc(32'h10);
      halt = 1; step("halt_enter");
      idle(); jump = 1; jump_index = 26'h123;
      for (int i = 0; i < 5; i++) step("halt_hold");
      chk("halt_pc", {32'd0, pc}, 64'h10);
      idle(); resume = 1; halt = 1;
      step("resume_edge");
      idle(); step("resume_next");
      chk("resume_pc", {32'd0, pc}, 64'h14);

      // halt and resume together in RUN: halt wins
      halt = 1; resume = 1; step("halt_resume_run");
      idle(); resume = 1; step("leave");

      // Exception overrides stall
      goto_pc(32'h30);
      exc = 1; stall = 1; step("exc_stall");
      chk("exc_epc", {32'd0, epc}, 64'h30);
      // Exception while halted
      idle(); goto_pc(32'h60);
      halt = 1; step("halt2");
      idle(); exc = 1; step("exc_halted");
      chk("exc_halted_epc", {32'd0, epc}, 64'h60);

      // Misaligned jr
      goto_pc(32'h50);
      jr = 1; jr_target = 32'h402; step("jr_mis");
      idle(); step("jr_mis_after");

      // Wrap
      goto_pc(32'hFFFF_FFFC);
      step("wrap");
      chk("wrap_pc", {32'd0, pc}, 64'h0);

      // Async reset mid-halt
      halt = 1; step("halt3");
      idle();
      #2 reset_n = 1'b0;
      model_reset();
      #1 chk_all("reset_mid_halt");
      @(posedge clk); #1 reset_n = 1'b1;

      // Async reset mid-stall after an exception set epc
      exc = 1; step("exc_pre");
      idle(); stall = 1; step("stall2");
      #2 reset_n = 1'b0;
      model_reset();
      #1 chk_all("reset_mid_stall");
      @(posedge clk); #1 reset_n = 1'b1;
      idle();

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         stall        = ($urandom_range(0, 99) < 15);
         branch_taken = ($urandom_range(0, 99) < 30);
         jump         = ($urandom_range(0, 99) < 15);
         jr           = ($urandom_range(0, 99) < 15);
         exc          = ($urandom_range(0, 99) < 4);
         halt         = ($urandom_range(0, 99) < 5);
         resume       = ($urandom_range(0, 99) < 30);
         branch_offset = 32'($signed($urandom_range(0, 64)) - 32);
         jump_index    = 26'($urandom);
         jr_target     = $urandom;
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle MIPS core. It holds the PC in a register and computes the next PC from a prioritised set of sources: sequential increment, conditional branch, pseudo-direct jump, jump-register and exception redirect. A two-state run/halt FSM and a stall input let the core freeze fetch. It replaces the purely combinational PC incrementer and feeds instruction memory directly.

## Interface
- WIDTH, 32, PC width in bits; legal range 32..64
- RESET_VEC, 0, PC value loaded on reset
- EXC_VEC, 32'h0000_0080, exception/trap target, zero-extended to WIDTH
- INC, 4, sequential increment in bytes
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC this cycle
- branch_taken  in  1  conditional branch resolved taken
- branch_offset  in  WIDTH  sign-extended word offset from the instruction immediate
- jump  in  1  J/JAL
- jump_index  in  26  instruction index field
- jr  in  1  JR/JALR
- jr_target  in  WIDTH  register-file value for jr
- exc  in  1  exception request
- halt  in  1  enter HALT
- resume  in  1  leave HALT
- pc  out  WIDTH  current PC (registered)
- pc_plus_inc  out  WIDTH  pc + INC (combinational, link value)
- epc  out  WIDTH  PC of the faulting instruction (registered)
- halted  out  1  FSM in HALT (registered)
- misalign  out  1  one-cycle pulse on a trapped misaligned jr

## Operation
- Targets; all arithmetic is modulo 2^WIDTH, and carries are discarded:
  - seq = pc + INC
  - br = seq + (branch_offset << 2)
  - jmp = {seq[WIDTH-1:28], jump_index, 2'b00}
  - jrt = jr_target
- Next-PC priority, highest first:
  - exc
  - HALT state (hold)
  - stall (hold)
  - jr
  - jump
  - branch_taken
  - seq
- Lower-priority requests asserted in the same cycle are ignored, not queued.
- exc: pc <= EXC_VEC, epc <= pc, FSM -> RUN. This applies in either state and overrides stall.
- FSM states RUN and HALT:
  - RUN, halt=1, exc=0 -> HALT. pc holds on the entry edge.
  - HALT, resume=1 -> RUN. pc holds on that edge; normal update resumes on the next edge.
  - HALT ignores stall, jr, jump and branch.
  - halt and resume asserted together in RUN: halt wins.
- epc changes only on exc or on a trapped misaligned jr.

## Timing
- Reset values (asynchronous, on reset_n low): pc=RESET_VEC, epc=0, halted=0, misalign=0, FSM=RUN.
- Release is synchronous to clk. The first update happens on the first rising edge with reset_n high.
- Every output except pc_plus_inc is registered. The selected target appears on pc one edge after the request is sampled, so latency is one cycle.
- halted rises on the edge that enters HALT and falls on the edge that leaves it.
- reset_n asserted mid-HALT or mid-stall returns every register to its reset value immediately.
- PC wraps silently: pc=2^WIDTH-INC followed by seq gives pc=0.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - jr with jr_target[1:0]!=0 (and exc=0, FSM in RUN, stall=0) is trapped: pc <= EXC_VEC, epc <= pc, misalign=1 for exactly one cycle.
- PC_ALIGN_CHECK_EN undefined:
  - jr loads {jr_target[WIDTH-1:2], 2'b00}.
  - misalign is tied to 0.

## Test plan
- Reset, then 3 free cycles, with RESET_VEC=0 -> pc sequence 0, 4, 8, 12; during reset_n=0 pc=0 and halted=0.
- At pc=0x100: branch_taken=1, branch_offset=-2 -> pc=0xFC. Next, at pc=0xFC: jump=1, jump_index=0x40 -> pc=0x100.
- At pc=0x200: jr=1, jump=1, branch_taken=1, jr_target=0x400 -> pc=0x400. Next cycle: stall=1 -> pc remains 0x400.
- halt pulse at pc=0x10 -> halted=1, pc stays 0x10 for 5 cycles despite jump. Then resume -> pc stays 0x10 one edge, then 0x14.
- At pc=0x30: exc=1 with stall=1, and separately exc=1 while halted -> pc=0x80, epc=0x30 (or the held PC), halted=0.
- With PC_ALIGN_CHECK_EN: jr_target=0x402 at pc=0x50 -> pc=0x80, epc=0x50, misalign high for 1 cycle. Without the macro: pc=0x400, misalign=0.
